vga_pattern_selector: RTL and testbench
=======================================

Name: vga_pattern_selector

Overview:
- Parametrised successor to the fixed three-pattern pixel mux in the VGA top level.
- Selects one of NUM_PATTERNS pattern generator outputs, or black, for the VGA pins.
- Pattern changes are deferred to frame boundaries so a frame never tears mid-way.
- Adds next/prev/direct selection, an auto-cycle mode, a pending flag, and sync signals delay-matched to the registered pixels.

Parameters:
- NUM_PATTERNS, 4: number of pattern input channels, range 1..255.
- COLOR_BITS, 3: bits per colour component.
- AUTO_FRAMES, 60: frames per pattern in auto-cycle mode, minimum 1.
- INIT_PATTERN, 0: pattern index loaded at reset, range 0..NUM_PATTERNS.
- SYNC_IDLE, 1: reset value of o_hs and o_vs.

Ports:
- i_clk  in  1  pixel clock
- i_reset  in  1  synchronous active-high reset
- i_hs  in  1  horizontal sync from timing generator
- i_vs  in  1  vertical sync from timing generator
- i_activeArea  in  1  high inside visible region
- i_frameStrobe  in  1  one-cycle pulse on first cycle of vertical blanking
- i_pixels  in  NUM_PATTERNS*3*COLOR_BITS  packed channels
  - channel k occupies bits [k*3*COLOR_BITS +: 3*COLOR_BITS], ordered {R,G,B} MSB first.
- i_selStrobe  in  1  direct select request
- i_selValue  in  8  pattern index for direct select
- i_nextStrobe  in  1  step to next pattern
- i_prevStrobe  in  1  step to previous pattern
- i_autoEnable  in  1  level, enables auto-cycle
- o_hs  out  1  i_hs delayed 1 cycle
- o_vs  out  1  i_vs delayed 1 cycle
- o_red  out  COLOR_BITS  red component
- o_green  out  COLOR_BITS  green component
- o_blue  out  COLOR_BITS  blue component
- o_pattern  out  8  active pattern index (0 = black)
- o_pending  out  1  request differs from active pattern

Behaviour:
- Single clock domain. Reset is synchronous and active-high, clock i_clk, reset i_reset.
- Reset values:
  - r_request = r_active = INIT_PATTERN, frame counter = 0.
  - o_red/o_green/o_blue = 0, o_hs = o_vs = SYNC_IDLE, o_pending = 0.
  - Reset wins over every other input in the same cycle; asserting it mid-frame takes effect on the next edge.
- Index map: pattern 0 = black; pattern p in 1..NUM_PATTERNS = channel p-1.
- Request register r_request, updated one cycle after a strobe. Priority sel > next > prev; lower-priority strobes in the same cycle are dropped.
  - sel: i_selValue is loaded only if <= NUM_PATTERNS; otherwise ignored, no change.
  - next: increments, NUM_PATTERNS wraps to 0.
  - prev: decrements, 0 wraps to NUM_PATTERNS.
- Auto mode (i_autoEnable=1):
  - Counter increments on each i_frameStrobe.
  - At a strobe with counter == AUTO_FRAMES-1: counter clears and request advances over 1..NUM_PATTERNS only (N wraps to 1, 0 goes to 1).
  - Any accepted manual strobe clears the counter.
  - i_autoEnable=0 holds the counter at 0.
- Commit: on i_frameStrobe, r_active loads the next-state request value. A manual or auto request arriving in the same cycle as the strobe is committed at that strobe.
  - Between strobes r_active never changes.
- o_pattern = r_active. o_pending = (r_request != r_active), registered.
- Pixel path, latency 1:
  - Colours = selected channel when i_activeArea=1 and r_active != 0.
  - Colours = 0 otherwise.
  - o_hs/o_vs register i_hs/i_vs in the same stage, so sync and pixels stay aligned.
- Index arithmetic is 8-bit unsigned. Comparisons against NUM_PATTERNS use the full 8 bits, so there is no truncation for any legal parameter.

Test Plan:
- Reset with INIT_PATTERN=0, i_activeArea=1, channel 0 = all-ones -> colours 0, o_pattern=0, o_hs=o_vs=1. Release -> colours stay 0.
- i_nextStrobe mid-frame -> o_pending=1 next cycle, o_pattern stays 0. After i_frameStrobe: o_pattern=1, o_pending=0, and colours equal channel 0 one cycle after i_activeArea rises.
- NUM_PATTERNS=4, active=4, next then frame strobe -> 0. Prev from 0 -> 4. i_selValue=5 -> ignored, o_pending stays 0. i_selValue=3 with next in same cycle -> committed 3.
- AUTO_FRAMES=2, auto on, active=4 -> after two frame strobes o_pattern=1, after two more =2. A manual next in between resets the count.
- Toggle i_hs/i_vs with i_activeArea=0 -> o_hs/o_vs follow with exactly 1 cycle delay, colours 0.
- i_reset pulsed mid-frame with request pending -> next cycle o_pattern=INIT_PATTERN, o_pending=0, counter 0.

Source files
------------

// File: rtl/vga_pattern_selector.sv
// vga_pattern_selector: frame-synchronous selection of one of NUM_PATTERNS pixel channels (or black)
// with next/prev/direct/auto-cycle requests and sync delay-matched to the registered pixels.
module vga_pattern_selector #(
    parameter int       NUM_PATTERNS = 4,
    parameter int       COLOR_BITS   = 3,
    parameter int       AUTO_FRAMES  = 60,
    parameter int       INIT_PATTERN = 0,
    parameter logic     SYNC_IDLE    = 1'b1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_hs,
    input  logic                                 i_vs,
    input  logic                                 i_activeArea,
    input  logic                                 i_frameStrobe,
    input  logic [NUM_PATTERNS*3*COLOR_BITS-1:0] i_pixels,
    input  logic                                 i_selStrobe,
    input  logic [7:0]                           i_selValue,
    input  logic                                 i_nextStrobe,
    input  logic                                 i_prevStrobe,
    input  logic                                 i_autoEnable,
    output logic                                 o_hs,
    output logic                                 o_vs,
    output logic [COLOR_BITS-1:0]                o_red,
    output logic [COLOR_BITS-1:0]                o_green,
    output logic [COLOR_BITS-1:0]                o_blue,
    output logic [7:0]                           o_pattern,
    output logic                                 o_pending
);
    localparam int              PW       = 3 * COLOR_BITS;
    localparam int              CW       = (AUTO_FRAMES < 2) ? 1 : $clog2(AUTO_FRAMES);
    localparam logic [7:0]      NP       = 8'(NUM_PATTERNS);
    localparam logic [7:0]      INIT     = 8'(INIT_PATTERN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(AUTO_FRAMES - 1);

    logic [7:0]    r_request, r_active, req_next, active_next, man_value;
    logic          sel_ok, man_hit, auto_wrap;
    logic [CW-1:0] r_count, count_next;
    logic [PW-1:0] chan_pix, r_pix;

    // An out-of-range direct select still owns the cycle, so it also masks next/prev.
    always_comb begin
        sel_ok      = i_selStrobe && (i_selValue <= NP);
        man_hit     = sel_ok || (!i_selStrobe && (i_nextStrobe || i_prevStrobe));
        man_value   = i_selStrobe  ? i_selValue :
                      i_nextStrobe ? ((r_request == NP) ? 8'd0 : r_request + 8'd1) :
                                     ((r_request == 8'd0) ? NP : r_request - 8'd1);
        auto_wrap   = i_autoEnable && i_frameStrobe && !man_hit && (r_count == CNT_LAST);
        req_next    = man_hit   ? man_value :
                      auto_wrap ? ((r_request >= NP) ? 8'd1 : r_request + 8'd1) :
                                  r_request;
        count_next  = (!i_autoEnable || man_hit || auto_wrap) ? '0 :
                      i_frameStrobe ? r_count + CW'(1) : r_count;
        active_next = i_frameStrobe ? req_next : r_active;
    end

    always_comb begin
        chan_pix = '0;
        for (int k = 0; k < NUM_PATTERNS; k++)
            if (r_active == 8'(k + 1)) chan_pix = i_pixels[k*PW +: PW];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_request <= INIT;
            r_active  <= INIT;
            r_count   <= '0;
            o_pending <= 1'b0;
            r_pix     <= '0;
            o_hs      <= SYNC_IDLE;
            o_vs      <= SYNC_IDLE;
        end else begin
            r_request <= req_next;
            r_active  <= active_next;
            r_count   <= count_next;
            o_pending <= req_next != active_next;
            r_pix     <= (i_activeArea && r_active != 8'd0) ? chan_pix : '0;
            o_hs      <= i_hs;
            o_vs      <= i_vs;
        end
    end

    assign o_red     = r_pix[2*COLOR_BITS +: COLOR_BITS];
    assign o_green   = r_pix[COLOR_BITS +: COLOR_BITS];
    assign o_blue    = r_pix[0 +: COLOR_BITS];
    assign o_pattern = r_active;
endmodule

// File: tb/tb_vga_pattern_selector.sv
// tb_vga_pattern_selector: directed stimulus, per-cycle comparison against an arithmetic
// model of the selection rules, plus hand-computed literal checks.
module tb_vga_pattern_selector;
    localparam int N  = 4;
    localparam int CB = 3;
    localparam int AF = 2;

    logic clk = 1'b0;
    logic rst, hs, vs, aa, fs, sel, nxt, prv, aut;
    logic [7:0] selv;
    logic [N*3*CB-1:0] pix;
    logic o_hs, o_vs, o_pending;
    logic [CB-1:0] o_red, o_green, o_blue;
    logic [7:0] o_pattern;
    logic [8:0] chan [N];

    initial begin
        chan[0] = 9'h1FF;
        chan[1] = 9'h0A5;
        chan[2] = 9'h14C;
        chan[3] = 9'h073;
    end
    assign pix = {chan[3], chan[2], chan[1], chan[0]};

    vga_pattern_selector #(
        .NUM_PATTERNS(N), .COLOR_BITS(CB), .AUTO_FRAMES(AF), .INIT_PATTERN(0), .SYNC_IDLE(1'b1)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_hs(hs), .i_vs(vs), .i_activeArea(aa),
        .i_frameStrobe(fs), .i_pixels(pix), .i_selStrobe(sel), .i_selValue(selv),
        .i_nextStrobe(nxt), .i_prevStrobe(prv), .i_autoEnable(aut),
        .o_hs(o_hs), .o_vs(o_vs), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_pattern(o_pattern), .o_pending(o_pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    int m_req, m_act, m_cnt, nr;
    bit man, m_ok = 1'b0;
    logic [8:0] e_pix;
    logic e_hs, e_vs, e_pend;

    // Model: indices live on the ring 0..N, auto-cycle on the ring 1..N.
    always @(posedge clk) begin
        if (rst) begin
            m_req = 0; m_act = 0; m_cnt = 0;
            e_pix = '0; e_hs = 1'b1; e_vs = 1'b1; e_pend = 1'b0;
            m_ok = 1'b1;
        end else if (m_ok) begin
            e_pix = (aa && m_act != 0) ? chan[m_act-1] : 9'd0;
            e_hs = hs;
            e_vs = vs;
            nr = m_req;
            man = 1'b0;
            if (sel) begin
                if (int'(selv) <= N) begin nr = int'(selv); man = 1'b1; end
            end else if (nxt) begin
                nr = (m_req + 1) % (N + 1); man = 1'b1;
            end else if (prv) begin
                nr = (m_req + N) % (N + 1); man = 1'b1;
            end
            if (!aut || man) m_cnt = 0;
            else if (fs) begin
                m_cnt++;
                if (m_cnt == AF) begin m_cnt = 0; nr = m_req % N + 1; end
            end
            m_req = nr;
            if (fs) m_act = nr;
            e_pend = (m_req != m_act);
        end
    end

    always @(posedge clk) begin
        #2;
        if (m_ok) begin
            chk("pattern", o_pattern, m_act);
            chk("pending", o_pending, e_pend);
            chk("red", o_red, e_pix[8:6]);
            chk("green", o_green, e_pix[5:3]);
            chk("blue", o_blue, e_pix[2:0]);
            chk("hs", o_hs, e_hs);
            chk("vs", o_vs, e_vs);
        end
    end

    task automatic pulse(input logic s, input logic n, input logic p, input logic f);
        sel = s; nxt = n; prv = p; fs = f;
        @(negedge clk);
        sel = 1'b0; nxt = 1'b0; prv = 1'b0; fs = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; aa = 1'b1; fs = 1'b0;
        sel = 1'b0; nxt = 1'b0; prv = 1'b0; aut = 1'b0; selv = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_red", o_red, 0);
        chk("rst_pattern", o_pattern, 0);
        chk("rst_hs", o_hs, 1);
        chk("rst_vs", o_vs, 1);
        hs = 1'b1; vs = 1'b1; rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("black_red", o_red, 0);

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("next_pend", o_pending, 1);
        chk("next_hold", o_pattern, 0);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("commit1", o_pattern, 1);
        chk("commit_pend", o_pending, 0);
        aa = 1'b0;
        @(negedge clk);
        chk("aa_off_red", o_red, 0);
        aa = 1'b1;
        @(negedge clk);
        chk("ch0_red", o_red, 7);
        chk("ch0_blue", o_blue, 7);

        selv = 8'd4;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sel4", o_pattern, 4);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_to_0", o_pattern, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_to_n", o_pattern, 4);
        selv = 8'd5;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sel5_pend", o_pending, 0);
        chk("sel5_pat", o_pattern, 4);
        selv = 8'd3;
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sel_prio", o_pattern, 3);
        @(negedge clk);
        chk("ch2_red", o_red, 5);
        chk("ch2_green", o_green, 1);
        chk("ch2_blue", o_blue, 4);

        selv = 8'd4;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_start", o_pattern, 4);
        aut = 1'b1;
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_hold", o_pattern, 4);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_1", o_pattern, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_2", o_pattern, 2);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_manual", o_pattern, 3);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("auto_4", o_pattern, 4);
        aut = 1'b0;

        aa = 1'b0; hs = 1'b0; vs = 1'b0;
        @(negedge clk);
        chk("sync_hs0", o_hs, 0);
        chk("sync_vs0", o_vs, 0);
        hs = 1'b1;
        @(negedge clk);
        chk("sync_hs1", o_hs, 1);
        chk("sync_vs_hold", o_vs, 0);
        chk("sync_red", o_red, 0);
        for (int i = 0; i < 8; i++) begin
            hs = i[0];
            vs = i[1];
            @(negedge clk);
        end

        aa = 1'b1; aut = 1'b1; selv = 8'd2;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_pend", o_pending, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_pat", o_pattern, 0);
        chk("rst_mid_pend", o_pending, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_cnt_hold", o_pattern, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_cnt_adv", o_pattern, 1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
